alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 83 ++++++++
 tb/tb_alu_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_arbiter_if #(parameter int DATA_W = 8, parameter int OP_W = 4);
   logic              req0_valid, req0_ready, req0_cin;
   logic [DATA_W-1:0] req0_a, req0_b;
   logic [OP_W-1:0]   req0_op;
   logic              req1_valid, req1_ready, req1_cin;
   logic [DATA_W-1:0] req1_a, req1_b;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [OP_W-1:0]   alu_opcode;
   logic              alu_cin, alu_zero, alu_carry, alu_overflow, alu_negative;
   logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [DATA_W-1:0] rsp_result;
   logic [3:0]        rsp_flags;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_op, req1_cin,
      input  alu_result, alu_zero, alu_carry, alu_overflow, alu_negative, rsp_ready,
      output req0_ready, req1_ready, alu_a, alu_b, alu_opcode, alu_cin,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_cin,
      output req1_valid, req1_a, req1_b, req1_op, req1_cin,
      output alu_result, alu_zero, alu_carry, alu_overflow, alu_negative, rsp_ready,
      input  req0_ready, req1_ready, alu_a, alu_b, alu_opcode, alu_cin,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin grant of the shared 8-bit ALU to two requesters,
// with registered operands and a held, requester-tagged response.
module alu_arbiter (
   input logic clk,
   input logic rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t     state_q;
   logic       last_grant_q, id_q, cin_q, rsp_valid_q, rsp_id_q, rsp_err_q;
   logic [7:0] a_q, b_q, rsp_result_q;
   logic [3:0] op_q, rsp_flags_q;
   logic       win, g0, g1, acc, sel, cin_d, undef;
   logic [7:0] a_d, b_d;
   logic [3:0] op_d;

   // rst_n gating keeps both readies low while reset is held
   assign win   = rst_n && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
   assign g0    = bus.req0_valid && (!bus.req1_valid || last_grant_q);
   assign g1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
   assign bus.req0_ready = win && g0;
   assign bus.req1_ready = win && g1;
   assign acc   = bus.req0_ready || bus.req1_ready;
   assign sel   = bus.req1_ready;
   assign a_d   = sel ? bus.req1_a   : bus.req0_a;
   assign b_d   = sel ? bus.req1_b   : bus.req0_b;
   assign op_d  = sel ? bus.req1_op  : bus.req0_op;
   assign cin_d = sel ? bus.req1_cin : bus.req0_cin;
   assign undef = op_q > 4'd9;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         cin_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            EXEC: begin
               rsp_id_q     <= id_q;
               rsp_err_q    <= undef;
               rsp_result_q <= undef ? 8'h00 : bus.alu_result;
               rsp_flags_q  <= undef ? 4'h0 : {bus.alu_zero, bus.alu_carry, bus.alu_overflow, bus.alu_negative};
               rsp_valid_q  <= 1'b1;
               state_q      <= RESP;
            end
            default: begin
               if (acc) begin
                  a_q          <= a_d;
                  b_q          <= b_d;
                  op_q         <= op_d;
                  cin_q        <= cin_d;
                  id_q         <= sel;
                  last_grant_q <= sel;
                  rsp_valid_q  <= 1'b0;
                  state_q      <= EXEC;
               end else if (state_q == RESP && bus.rsp_ready) begin
                  rsp_valid_q  <= 1'b0;
                  state_q      <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_opcode = op_q;
   assign bus.alu_cin    = cin_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against alu_arbiter with a behavioural ALU
// attached to the ALU side; expected responses are hand-computed constants.
module tb_alu_arbiter;
   logic clk, rst_n;
   int   checks = 0, errors = 0;
   logic [8:0] s;
   logic       c, v, legal;

   alu_arbiter_if bus ();
   alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; undefined opcodes return junk so the arbiter must mask it
   always_comb begin
      s = '0;
      c = 1'b0;
      v = 1'b0;
      legal = 1'b1;
      case (bus.alu_opcode)
         4'd0: begin
            s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'b0, bus.alu_cin};
            c = s[8];
            v = (bus.alu_a[7] == bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
         end
         4'd1: begin
            s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'b0, bus.alu_cin};
            c = s[8];
            v = (bus.alu_a[7] != bus.alu_b[7]) && (s[7] != bus.alu_a[7]);
         end
         4'd2: s = {1'b0, bus.alu_a & bus.alu_b};
         4'd3: s = {1'b0, bus.alu_a | bus.alu_b};
         4'd4: s = {1'b0, bus.alu_a ^ bus.alu_b};
         4'd5: s = {1'b0, ~bus.alu_a};
         4'd6: s = {8'b0, (bus.alu_a != 0) && (bus.alu_b != 0)};
         4'd7: s = {8'b0, (bus.alu_a != 0) || (bus.alu_b != 0)};
         4'd8: s = {8'b0, (bus.alu_a != 0) ^ (bus.alu_b != 0)};
         4'd9: s = {8'b0, bus.alu_a == 0};
         default: legal = 1'b0;
      endcase
      bus.alu_result   = legal ? s[7:0] : 8'hA5;
      bus.alu_zero     = legal ? (s[7:0] == 8'h00) : 1'b1;
      bus.alu_carry    = legal ? c : 1'b1;
      bus.alu_overflow = legal ? v : 1'b1;
      bus.alu_negative = legal ? s[7] : 1'b1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic cin, input logic vld);
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_cin = cin; bus.req1_valid = vld;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_cin = cin; bus.req0_valid = vld;
      end
   endtask

   // Single request with rsp_ready high: handshake, EXEC, RESP, retire
   task automatic run_op(input string tag, input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic cin,
                         input logic [7:0] res, input logic [3:0] flg, input logic err);
      int n = 0;
      set_req(id, a, b, op, cin, 1'b1);
      #1;
      while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
         cyc;
         n++;
      end
      check({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
      cyc;
      set_req(id, a, b, op, cin, 1'b0);
      #1;
      check({tag, "_exec_valid"}, bus.rsp_valid, 0);
      cyc;
      check({tag, "_valid"},  bus.rsp_valid,  1);
      check({tag, "_id"},     bus.rsp_id,     id);
      check({tag, "_result"}, bus.rsp_result, res);
      check({tag, "_flags"},  bus.rsp_flags,  flg);
      check({tag, "_err"},    bus.rsp_err,    err);
      cyc;
      check({tag, "_retired"}, bus.rsp_valid, 0);
   endtask

   initial begin
      logic e;
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      set_req(1'b1, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0);
      set_req(1'b0, 8'd5, 8'd6, 4'd0, 1'b0, 1'b1);
      repeat (2) cyc;
      check("rst_ready0",  bus.req0_ready, 0);
      check("rst_valid",   bus.rsp_valid,  0);
      check("rst_id",      bus.rsp_id,     0);
      check("rst_result",  bus.rsp_result, 0);
      check("rst_flags",   bus.rsp_flags,  0);
      check("rst_err",     bus.rsp_err,    0);
      check("rst_alu",     {bus.alu_a, bus.alu_b}, 0);
      check("rst_aluop",   {bus.alu_opcode, bus.alu_cin}, 0);
      rst_n = 1'b1;
      #1;
      check("idle_ready0", bus.req0_ready, 1);
      cyc;
      check("exec_alu_a",  bus.alu_a, 5);
      check("exec_alu_b",  bus.alu_b, 6);
      bus.req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_alu_a", bus.alu_a, 0);
      check("async_valid", bus.rsp_valid, 0);
      cyc;
      rst_n = 1'b1;
      cyc;
      check("post_rst_valid", bus.rsp_valid, 0);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check("first_grant0", bus.req0_ready, 1);
      check("first_grant1", bus.req1_ready, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;

      run_op("add0", 1'b0, 8'd10,  8'd20, 4'd0, 1'b0, 8'd30,  4'b0000, 1'b0);
      run_op("add1", 1'b1, 8'd127, 8'd1,  4'd0, 1'b0, 8'd128, 4'b0011, 1'b0);
      run_op("sub1", 1'b1, 8'd20,  8'd50, 4'd1, 1'b0, 8'd226, 4'b0101, 1'b0);

      // Both requesters stream; last accept was requester 1, so 0 goes first
      set_req(1'b0, 8'd1, 8'd1, 4'd0, 1'b0, 1'b1);
      set_req(1'b1, 8'd3, 8'd3, 4'd0, 1'b0, 1'b1);
      #1;
      for (int i = 0; i < 4; i++) begin
         e = i[0];
         check("rr_ready0", bus.req0_ready, !e);
         check("rr_ready1", bus.req1_ready, e);
         cyc;
         check("rr_exec_busy", {bus.req0_ready, bus.req1_ready}, 0);
         cyc;
         check("rr_id",     bus.rsp_id, e);
         check("rr_result", bus.rsp_result, e ? 8'd6 : 8'd2);
      end

      bus.rsp_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", {bus.req0_ready, bus.req1_ready}, 0);
         check("stall_valid", bus.rsp_valid, 1);
         check("stall_rsp",   {bus.rsp_id, bus.rsp_result}, {1'b1, 8'd6});
         cyc;
      end
      check("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b1, 8'd6});
      bus.rsp_ready = 1'b1;
      #1;
      check("release_grant0", bus.req0_ready, 1);
      cyc;
      check("release_exec", bus.rsp_valid, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      cyc;
      check("release_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b0, 8'd2});
      cyc;

      run_op("undef", 1'b0, 8'd5,   8'd5,   4'b1111, 1'b0, 8'd0,  4'b0000, 1'b1);
      run_op("after", 1'b0, 8'd200, 8'd100, 4'd0,    1'b1, 8'd45, 4'b0100, 1'b0);
      run_op("xor1",  1'b1, 8'hF0,  8'hF0,  4'd4,    1'b0, 8'd0,  4'b1000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
